// File: rtl/hv_ngram_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : hv_ngram_encoder_if
// Brief    : Valid/ready hypervector stream with a sequence-start sideband.
// Revision : 1.0
// ============================================================================
interface hv_ngram_encoder_if #(
    parameter int HV_DIMENSION = 1024
) ();
    logic                    valid;
    logic                    ready;
    logic                    first;
    logic [HV_DIMENSION-1:0] data;

    modport master (output valid, output data, output first, input  ready);
    modport slave  (input  valid, input  data, input  first, output ready);
endinterface
`default_nettype wire

// File: rtl/hv_ngram_encoder.sv
`default_nettype none
// ============================================================================
// Module   : hv_ngram_encoder
// Brief    : Sliding-window temporal N-gram encoder (XOR of rotated history).
// Revision : 1.0
// ============================================================================
module hv_ngram_encoder #(
    parameter int NGRAM_SIZE   = 3,
    parameter int CNT_WIDTH    = 16,
    parameter int HV_DIMENSION = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    hv_ngram_encoder_if.slave    upstream,
    hv_ngram_encoder_if.master   downstream,
    output logic [CNT_WIDTH-1:0] ngram_count
);

    localparam int FILL_W = (NGRAM_SIZE > 1) ? $clog2(NGRAM_SIZE) : 1;
    localparam logic [FILL_W-1:0] C_FULL = FILL_W'(NGRAM_SIZE - 1);

    logic                    r_valid;
    logic [HV_DIMENSION-1:0] r_hv;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [FILL_W-1:0]       r_fill;

    logic                    w_in_ready;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [FILL_W-1:0]       w_eff_fill;
    logic                    w_complete;
    logic [HV_DIMENSION-1:0] w_hist_xor;
    logic [HV_DIMENSION-1:0] w_ngram;

    function automatic logic [HV_DIMENSION-1:0] rotl(input logic [HV_DIMENSION-1:0] v,
                                                     input int k);
        return (v << k) | (v >> (HV_DIMENSION - k));
    endfunction

    // Single output stage: accept whenever the output slot is empty or draining.
    assign w_in_ready = !r_valid | downstream.ready;
    assign w_in_fire  = upstream.valid & w_in_ready;
    assign w_out_fire = r_valid & downstream.ready;
    assign w_eff_fill = upstream.first ? '0 : r_fill;
    assign w_complete = (w_eff_fill == C_FULL);
    assign w_ngram    = upstream.data ^ w_hist_xor;

    assign upstream.ready   = w_in_ready;
    assign downstream.valid = r_valid;
    assign downstream.data  = r_hv;
    assign downstream.first = 1'b0;
    assign ngram_count      = r_count;

    generate
        if (NGRAM_SIZE > 1) begin : g_hist
            logic [HV_DIMENSION-1:0] r_hist [NGRAM_SIZE-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                        r_hist[k] <= '0;
                    end
                end else if (w_in_fire) begin
                    r_hist[0] <= upstream.data;
                    for (int k = 1; k < NGRAM_SIZE - 1; k++) begin
                        r_hist[k] <= upstream.first ? '0 : r_hist[k-1];
                    end
                end
            end

            // hist[k-1] is k samples old and is rotated by k.
            always_comb begin
                w_hist_xor = '0;
                for (int k = 1; k < NGRAM_SIZE; k++) begin
                    w_hist_xor = w_hist_xor ^ rotl(r_hist[k-1], k);
                end
            end
        end else begin : g_nohist
            assign w_hist_xor = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
        end else if (w_in_fire) begin
            r_fill <= w_complete ? w_eff_fill : w_eff_fill + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_hv    <= '0;
        end else if (w_in_fire && w_complete) begin
            r_valid <= 1'b1;
            r_hv    <= w_ngram;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_in_fire && w_complete && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire
